// File: rtl/axi_wrap_master.sv
// rtl/axi_wrap_master.sv - simplified wrap_* bus to AXI3 master, one read and one write outstanding
// Optional AXI_RAW_ORDER_EN: reads wait for any in-flight write to complete; writes win same-cycle ties.
module axi_wrap_master #(
  parameter int ID_W  = 4,
  parameter int RD_ID = 0,
  parameter int WR_ID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     wrap_araddr,
  input  logic [3:0]      wrap_arlen,
  input  logic [2:0]      wrap_arsize,
  input  logic            wrap_arvalid,
  output logic            wrap_arready,
  output logic [31:0]     wrap_rdata,
  output logic            wrap_rlast,
  output logic            wrap_rvalid,
  input  logic            wrap_rready,
  input  logic [31:0]     wrap_awaddr,
  input  logic [3:0]      wrap_awlen,
  input  logic [2:0]      wrap_awsize,
  input  logic            wrap_awvalid,
  output logic            wrap_awready,
  input  logic [31:0]     wrap_wdata,
  input  logic [3:0]      wrap_wstrb,
  input  logic            wrap_wlast,
  input  logic            wrap_wvalid,
  output logic            wrap_wready,
  output logic            wrap_bvalid,
  input  logic            wrap_bready,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output logic            bus_err
);

`ifdef AXI_RAW_ORDER_EN
  localparam bit RAW_ORDER = 1'b1;
`else
  localparam bit RAW_ORDER = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

  rstate_t     r_rstate;
  wstate_t     r_wstate;
  logic [31:0] r_araddr;
  logic [3:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic        r_arvalid;
  logic [3:0]  r_rcnt;
  logic [31:0] r_awaddr;
  logic [3:0]  r_awlen;
  logic [2:0]  r_awsize;
  logic        r_awvalid;
  logic [3:0]  r_wcnt;
  logic        r_bus_err;

  logic w_ar_ok;
  logic w_aw_ok;
  logic w_r_data;
  logic w_w_data;
  logic w_w_resp;
  logic w_r_beat;
  logic w_w_beat;
  logic w_w_last;
  logic w_b_hs;
  logic w_rd_err;
  logic w_wr_err;
  logic w_unused;

  assign w_unused = ^{rid, bid, wrap_wlast};

  // With ordering on, a read only enters when no write is in flight or being offered.
  assign w_ar_ok  = ~rst && (r_rstate == R_IDLE) &&
                    (!RAW_ORDER || ((r_wstate == W_IDLE) && !wrap_awvalid));
  assign w_aw_ok  = ~rst && (r_wstate == W_IDLE);
  assign w_r_data = (r_rstate == R_DATA);
  assign w_w_data = (r_wstate == W_DATA);
  assign w_w_resp = (r_wstate == W_RESP);

  assign w_r_beat = w_r_data && rvalid && wrap_rready;
  assign w_w_last = (r_wcnt == r_awlen);
  assign w_w_beat = w_w_data && wrap_wvalid && wready;
  assign w_b_hs   = w_w_resp && bvalid && wrap_bready;
  assign w_rd_err = w_r_beat && ((rresp != 2'b00) || (rlast && (r_rcnt != r_arlen)));
  assign w_wr_err = w_b_hs && (bresp != 2'b00);

  assign wrap_arready = w_ar_ok;
  assign wrap_awready = w_aw_ok;

  assign arid    = ID_W'(RD_ID);
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = r_arvalid;

  assign wrap_rdata  = rdata;
  assign wrap_rlast  = w_r_data && rlast;
  assign wrap_rvalid = w_r_data && rvalid;
  assign rready      = w_r_data && wrap_rready;

  assign awid    = ID_W'(WR_ID);
  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awsize  = r_awsize;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = r_awvalid;

  // wlast is rebuilt from the beat count; the bridge's own wlast is not trusted.
  assign wid         = ID_W'(WR_ID);
  assign wdata       = wrap_wdata;
  assign wstrb       = wrap_wstrb;
  assign wlast       = w_w_data && w_w_last;
  assign wvalid      = w_w_data && wrap_wvalid;
  assign wrap_wready = w_w_data && wready;
  assign wrap_bvalid = w_w_resp && bvalid;
  assign bready      = w_w_resp && wrap_bready;
  assign bus_err     = r_bus_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arvalid <= 1'b0;
      r_rcnt    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (wrap_arvalid && w_ar_ok) begin
            r_araddr  <= wrap_araddr;
            r_arlen   <= wrap_arlen;
            r_arsize  <= wrap_arsize;
            r_arvalid <= 1'b1;
            r_rstate  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rcnt    <= '0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_beat) begin
            if (r_rcnt != 4'hF) r_rcnt <= r_rcnt + 4'd1;
            if (rlast) r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awvalid <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (wrap_awvalid && w_aw_ok) begin
            r_awaddr  <= wrap_awaddr;
            r_awlen   <= wrap_awlen;
            r_awsize  <= wrap_awsize;
            r_awvalid <= 1'b1;
            r_wstate  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (awready) begin
            r_awvalid <= 1'b0;
            r_wcnt    <= '0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_beat) begin
            if (r_wcnt != 4'hF) r_wcnt <= r_wcnt + 4'd1;
            if (w_w_last) r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (w_b_hs) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_bus_err <= 1'b0;
    else if (w_rd_err || w_wr_err) r_bus_err <= 1'b1;
  end

endmodule

// File: tb/tb_axi_wrap_master.sv
// tb/tb_axi_wrap_master.sv - directed self-checking bench for axi_wrap_master
// Honours AXI_RAW_ORDER_EN to pick the expected same-cycle AR/AW behaviour.
module tb_axi_wrap_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wrap_araddr = '0;
  logic [3:0]  wrap_arlen = '0;
  logic [2:0]  wrap_arsize = '0;
  logic        wrap_arvalid = 1'b0;
  logic        wrap_arready;
  logic [31:0] wrap_rdata;
  logic        wrap_rlast;
  logic        wrap_rvalid;
  logic        wrap_rready = 1'b0;
  logic [31:0] wrap_awaddr = '0;
  logic [3:0]  wrap_awlen = '0;
  logic [2:0]  wrap_awsize = '0;
  logic        wrap_awvalid = 1'b0;
  logic        wrap_awready;
  logic [31:0] wrap_wdata = '0;
  logic [3:0]  wrap_wstrb = '0;
  logic        wrap_wlast = 1'b0;
  logic        wrap_wvalid = 1'b0;
  logic        wrap_wready;
  logic        wrap_bvalid;
  logic        wrap_bready = 1'b0;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [3:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_wrap_master #(.ID_W(4), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .rst(rst),
    .wrap_araddr(wrap_araddr), .wrap_arlen(wrap_arlen), .wrap_arsize(wrap_arsize),
    .wrap_arvalid(wrap_arvalid), .wrap_arready(wrap_arready),
    .wrap_rdata(wrap_rdata), .wrap_rlast(wrap_rlast), .wrap_rvalid(wrap_rvalid),
    .wrap_rready(wrap_rready),
    .wrap_awaddr(wrap_awaddr), .wrap_awlen(wrap_awlen), .wrap_awsize(wrap_awsize),
    .wrap_awvalid(wrap_awvalid), .wrap_awready(wrap_awready),
    .wrap_wdata(wrap_wdata), .wrap_wstrb(wrap_wstrb), .wrap_wlast(wrap_wlast),
    .wrap_wvalid(wrap_wvalid), .wrap_wready(wrap_wready),
    .wrap_bvalid(wrap_bvalid), .wrap_bready(wrap_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    n_cmp++; if ({wrap_arready, wrap_awready, wrap_wready, wrap_rvalid, wrap_bvalid, bus_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_wrap got %b want 000000",
                        {wrap_arready, wrap_awready, wrap_wready, wrap_rvalid, wrap_bvalid, bus_err});
    end
    n_cmp++; if ({araddr, awaddr} !== 64'h0) begin
      n_bad++; $display("FAIL reset_payload got %h want 0", {araddr, awaddr});
    end
    rst = 1'b0;
    #1;
    n_cmp++; if ({wrap_arready, wrap_awready} !== 2'b11) begin
      n_bad++; $display("FAIL reset_release_ready got %b want 11", {wrap_arready, wrap_awready});
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_d;
    wrap_araddr = 32'h1FC0_0000; wrap_arlen = 4'd3; wrap_arsize = 3'd2; wrap_arvalid = 1'b1;
    #1;
    n_cmp++; if (wrap_arready !== 1'b1) begin
      n_bad++; $display("FAIL rd_wrap_arready got %b want 1", wrap_arready);
    end
    tick();
    wrap_arvalid = 1'b0; wrap_araddr = '0; wrap_arlen = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h1FC0_0000, 4'd3, 3'd2, 2'b01, 4'd0}) begin
        n_bad++; $display("FAIL rd_ar_hold%0d got v=%b a=%h l=%0d b=%b id=%0d", i, arvalid, araddr, arlen, arburst, arid);
      end
      if (i == 2) arready = 1'b1;
      else tick();
    end
    tick();
    arready = 1'b0;
    n_cmp++; if (arvalid !== 1'b0) begin
      n_bad++; $display("FAIL rd_ar_drop got %b want 0", arvalid);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'hA0 + i;
      rvalid = 1'b1; rdata = exp_d; rlast = (i == 3); rresp = 2'b00; wrap_rready = 1'b1;
      #1;
      n_cmp++; if ({wrap_rvalid, wrap_rdata, wrap_rlast, rready} !== {1'b1, exp_d, (i == 3), 1'b1}) begin
        n_bad++; $display("FAIL rd_beat%0d got v=%b d=%h l=%b rr=%b want d=%h l=%b",
                          i, wrap_rvalid, wrap_rdata, wrap_rlast, rready, exp_d, (i == 3));
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; wrap_rready = 1'b0;
    #1;
    n_cmp++; if ({wrap_arready, wrap_rvalid, rready, bus_err} !== 4'b1000) begin
      n_bad++; $display("FAIL rd_idle got %b want 1000", {wrap_arready, wrap_rvalid, rready, bus_err});
    end
  endtask

  task automatic test_write_burst();
    wrap_awaddr = 32'h0000_0100; wrap_awlen = 4'd1; wrap_awsize = 3'd2; wrap_awvalid = 1'b1;
    tick();
    wrap_awvalid = 1'b0;
    n_cmp++; if ({awvalid, awaddr, awlen, awburst, awid, wrap_awready} !== {1'b1, 32'h100, 4'd1, 2'b01, 4'd1, 1'b0}) begin
      n_bad++; $display("FAIL wr_aw got v=%b a=%h l=%0d b=%b id=%0d rdy=%b", awvalid, awaddr, awlen, awburst, awid, wrap_awready);
    end
    n_cmp++; if (wvalid !== 1'b0) begin
      n_bad++; $display("FAIL wr_wvalid_early got %b want 0", wvalid);
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wrap_wvalid = 1'b1; wrap_wdata = (i == 0) ? 32'h11 : 32'h22; wrap_wstrb = 4'hF; wrap_wlast = 1'b0; wready = 1'b1;
      #1;
      n_cmp++; if ({wvalid, wdata, wstrb, wlast, wrap_wready, wid} !== {1'b1, wrap_wdata, 4'hF, (i == 1), 1'b1, 4'd1}) begin
        n_bad++; $display("FAIL wr_beat%0d got v=%b d=%h s=%h l=%b rdy=%b id=%0d", i, wvalid, wdata, wstrb, wlast, wrap_wready, wid);
      end
      tick();
    end
    wready = 1'b0;
    n_cmp++; if (wvalid !== 1'b0) begin
      n_bad++; $display("FAIL wr_wvalid_resp got %b want 0", wvalid);
    end
    wrap_wvalid = 1'b0;
    bvalid = 1'b1; bresp = 2'b00; wrap_bready = 1'b1;
    #1;
    n_cmp++; if ({wrap_bvalid, bready, wrap_awready} !== 3'b110) begin
      n_bad++; $display("FAIL wr_b got %b want 110", {wrap_bvalid, bready, wrap_awready});
    end
    tick();
    bvalid = 1'b0; wrap_bready = 1'b0;
    #1;
    n_cmp++; if ({wrap_awready, wrap_bvalid, bready, bus_err} !== 4'b1000) begin
      n_bad++; $display("FAIL wr_idle got %b want 1000", {wrap_awready, wrap_bvalid, bready, bus_err});
    end
  endtask

  task automatic test_rresp_error();
    wrap_araddr = 32'h40; wrap_arlen = 4'd0; wrap_arvalid = 1'b1;
    tick();
    wrap_arvalid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD; rlast = 1'b1; rresp = 2'b10; wrap_rready = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; wrap_rready = 1'b0;
    n_cmp++; if (bus_err !== 1'b1) begin
      n_bad++; $display("FAIL err_rresp got %b want 1", bus_err);
    end
    wrap_araddr = 32'h44; wrap_arvalid = 1'b1;
    tick();
    wrap_arvalid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; wrap_rready = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0; wrap_rready = 1'b0;
    n_cmp++; if ({bus_err, wrap_arready} !== 2'b11) begin
      n_bad++; $display("FAIL err_sticky got %b want 11", {bus_err, wrap_arready});
    end
    do_reset();
    n_cmp++; if (bus_err !== 1'b0) begin
      n_bad++; $display("FAIL err_clear got %b want 0", bus_err);
    end
  endtask

  task automatic test_short_burst();
    wrap_araddr = 32'h80; wrap_arlen = 4'd3; wrap_arvalid = 1'b1;
    tick();
    wrap_arvalid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'hB0 + i; rlast = (i == 1); wrap_rready = 1'b1;
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; wrap_rready = 1'b0;
    n_cmp++; if ({bus_err, wrap_arready} !== 2'b11) begin
      n_bad++; $display("FAIL short_end got %b want 11", {bus_err, wrap_arready});
    end
    wrap_araddr = 32'hC0; wrap_arlen = 4'd2; wrap_arvalid = 1'b1;
    tick();
    wrap_arvalid = 1'b0;
    n_cmp++; if ({arvalid, araddr, arlen} !== {1'b1, 32'hC0, 4'd2}) begin
      n_bad++; $display("FAIL short_next got v=%b a=%h l=%0d", arvalid, araddr, arlen);
    end
    do_reset();
  endtask

  task automatic test_simultaneous();
    wrap_araddr = 32'h200; wrap_arlen = 4'd0; wrap_arvalid = 1'b1;
    wrap_awaddr = 32'h300; wrap_awlen = 4'd0; wrap_awvalid = 1'b1;
    #1;
`ifdef AXI_RAW_ORDER_EN
    n_cmp++; if ({wrap_awready, wrap_arready} !== 2'b10) begin
      n_bad++; $display("FAIL sim_ready got %b want 10", {wrap_awready, wrap_arready});
    end
    tick();
    wrap_awvalid = 1'b0;
    n_cmp++; if ({awvalid, arvalid} !== 2'b10) begin
      n_bad++; $display("FAIL sim_aw_first got %b want 10", {awvalid, arvalid});
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wrap_wvalid = 1'b1; wrap_wdata = 32'h77; wready = 1'b1;
    tick();
    wrap_wvalid = 1'b0; wready = 1'b0;
    bvalid = 1'b1; wrap_bready = 1'b1;
    #1;
    n_cmp++; if ({arvalid, wrap_arready} !== 2'b00) begin
      n_bad++; $display("FAIL sim_ar_blocked got %b want 00", {arvalid, wrap_arready});
    end
    tick();
    bvalid = 1'b0; wrap_bready = 1'b0;
    n_cmp++; if ({arvalid, wrap_arready} !== 2'b01) begin
      n_bad++; $display("FAIL sim_ar_open got %b want 01", {arvalid, wrap_arready});
    end
    tick();
    wrap_arvalid = 1'b0;
    n_cmp++; if ({arvalid, araddr} !== {1'b1, 32'h200}) begin
      n_bad++; $display("FAIL sim_ar_after got v=%b a=%h", arvalid, araddr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; wrap_rready = 1'b1;
    tick();
    rvalid = 1'b0; rlast = 1'b0; wrap_rready = 1'b0;
`else
    n_cmp++; if ({wrap_awready, wrap_arready} !== 2'b11) begin
      n_bad++; $display("FAIL sim_ready got %b want 11", {wrap_awready, wrap_arready});
    end
    tick();
    wrap_awvalid = 1'b0; wrap_arvalid = 1'b0;
    n_cmp++; if ({awvalid, arvalid, awaddr, araddr} !== {2'b11, 32'h300, 32'h200}) begin
      n_bad++; $display("FAIL sim_both got aw=%b ar=%b awa=%h ara=%h", awvalid, arvalid, awaddr, araddr);
    end
    awready = 1'b1; arready = 1'b1;
    tick();
    awready = 1'b0; arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55; wrap_rready = 1'b1;
    wrap_wvalid = 1'b1; wrap_wdata = 32'h77; wready = 1'b1;
    #1;
    n_cmp++; if ({wrap_rvalid, wrap_rlast, wvalid, wlast} !== 4'b1111) begin
      n_bad++; $display("FAIL sim_data got %b want 1111", {wrap_rvalid, wrap_rlast, wvalid, wlast});
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0; wrap_rready = 1'b0; wrap_wvalid = 1'b0; wready = 1'b0;
    bvalid = 1'b1; wrap_bready = 1'b1;
    tick();
    bvalid = 1'b0; wrap_bready = 1'b0;
`endif
    n_cmp++; if ({wrap_arready, wrap_awready, bus_err} !== 3'b110) begin
      n_bad++; $display("FAIL sim_idle got %b want 110", {wrap_arready, wrap_awready, bus_err});
    end
  endtask

  task automatic test_mid_reset();
    wrap_araddr = 32'h500; wrap_arlen = 4'd3; wrap_arvalid = 1'b1;
    tick();
    wrap_arvalid = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hC0; rlast = 1'b0; wrap_rready = 1'b1;
    tick();
    rdata = 32'hC1;
    #1;
    n_cmp++; if ({wrap_rvalid, rready} !== 2'b11) begin
      n_bad++; $display("FAIL mid_beat2 got %b want 11", {wrap_rvalid, rready});
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({wrap_rvalid, rready, arvalid, awvalid, wvalid, wrap_arready} !== 6'b0) begin
      n_bad++; $display("FAIL mid_async got %b want 000000", {wrap_rvalid, rready, arvalid, awvalid, wvalid, wrap_arready});
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if ({wrap_arready, wrap_rvalid, bus_err} !== 3'b100) begin
      n_bad++; $display("FAIL mid_release got %b want 100", {wrap_arready, wrap_rvalid, bus_err});
    end
    rvalid = 1'b0; wrap_rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_rresp_error();
    test_short_burst();
    test_simultaneous();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
